// File: rtl/microwave_pkg.sv
// microwave_pkg -- shared FSM encodings, BCD time type and time-edit helpers
// for the cook timer. Every helper keeps the time in BCD digits throughout.
package microwave_pkg;

  localparam int BCD_W     = 4;
  localparam int MAX_MIN   = 99;
  localparam int QUICK_SEC = 30;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX      = bcd_digit_t'(9);
  localparam bcd_digit_t SEC_TENS_MAX   = bcd_digit_t'(5);
  localparam bcd_digit_t MAX_MIN_TENS   = bcd_digit_t'(MAX_MIN / 10);
  localparam bcd_digit_t MAX_MIN_ONES   = bcd_digit_t'(MAX_MIN % 10);
  localparam bcd_digit_t QUICK_SEC_TENS = bcd_digit_t'(QUICK_SEC / 10);
  localparam bcd_digit_t QUICK_SEC_ONES = bcd_digit_t'(QUICK_SEC % 10);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    bcd_digit_t min_tens;
    bcd_digit_t min_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
  } bcd_time_t;

  localparam bcd_time_t QUICK_TIME = '{
    min_tens: '0, min_ones: '0, sec_tens: QUICK_SEC_TENS, sec_ones: QUICK_SEC_ONES
  };

  function automatic logic min_at_max(input bcd_time_t t);
    return (t.min_tens == MAX_MIN_TENS) && (t.min_ones == MAX_MIN_ONES);
  endfunction

  // Add one minute, saturating at MAX_MIN; seconds are untouched.
  function automatic bcd_time_t add_minute(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (!min_at_max(t)) begin
      if (t.min_ones == DIGIT_MAX) begin
        r.min_ones = '0;
        r.min_tens = t.min_tens + 1'b1;
      end else begin
        r.min_ones = t.min_ones + 1'b1;
      end
    end
    return r;
  endfunction

  // Add ten seconds with carry into minutes; the total pins at 99:59.
  function automatic bcd_time_t add_ten_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_tens != SEC_TENS_MAX) begin
      r.sec_tens = t.sec_tens + 1'b1;
    end else if (min_at_max(t)) begin
      r.sec_tens = SEC_TENS_MAX;
      r.sec_ones = DIGIT_MAX;
    end else begin
      r          = add_minute(t);
      r.sec_tens = '0;
    end
    return r;
  endfunction

  // Button edits: the minute is applied before the ten seconds.
  function automatic bcd_time_t apply_edits(input bcd_time_t t, input logic add_min,
                                            input logic add_sec);
    bcd_time_t r;
    r = t;
    if (add_min) r = add_minute(r);
    if (add_sec) r = add_ten_sec(r);
    return r;
  endfunction

  // One-second countdown with a pure BCD borrow chain; caller guarantees t != 0.
  function automatic bcd_time_t sub_second(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - 1'b1;
    end else begin
      r.sec_ones = DIGIT_MAX;
      if (t.sec_tens != '0) begin
        r.sec_tens = t.sec_tens - 1'b1;
      end else begin
        r.sec_tens = SEC_TENS_MAX;
        if (t.min_ones != '0) begin
          r.min_ones = t.min_ones - 1'b1;
        end else begin
          r.min_ones = DIGIT_MAX;
          r.min_tens = t.min_tens - 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler -- divides clk down to a one-cycle tick every CLK_HZ enabled
// cycles. restart zeroes the count; enable low freezes it where it is.
module tick_prescaler #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Count enabled cycles, wrapping on the tick; restart wins over enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values, whatever the block order.
    if (!rst)         count <= '0;
    else if (restart) count <= '0;
    else if (enable)  count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/cook_timer.sv
// cook_timer -- microwave countdown timer: SET/RUN/PAUSE/DONE FSM over a BCD
// mm:ss time, decremented once per CLK_HZ cycles while running.
// Optional feature: define COOK_TIMER_QUICKSTART_EN so that start at 00:00
// in SET loads 00:30 and begins cooking on the same edge.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int CLK_HZ = 100000000  // cycles per 1 s tick, must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       timerEnd
);

  state_t    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic      tick;
  logic      pre_enable;
  logic      pre_restart;

  // Count only while cooking; SET/DONE (and any clear) rewind the prescaler so
  // a fresh run gets a full CLK_HZ before its first decrement, while PAUSE keeps it.
  assign pre_enable  = (state_q == ST_RUN) && start && !clear;
  assign pre_restart = (state_q == ST_SET) || (state_q == ST_DONE) || clear;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .enable  (pre_enable),
    .restart (pre_restart),
    .tick    (tick)
  );

  // State, time and status flags; the flags track the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_SET;
      time_q   <= '0;
      running  <= 1'b0;
      timerEnd <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      running  <= (state_d == ST_RUN);
      timerEnd <= (state_d == ST_DONE);
    end
  end

  // Next-state decode; clear takes priority over every other input.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_d = state_q;
    case (state_q)
      ST_SET: begin
        if (clear) begin
          state_d = ST_SET;
        end else if (start) begin
`ifdef COOK_TIMER_QUICKSTART_EN
          state_d = ST_RUN;
`else
          if (time_q != '0) state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (clear)                                  state_d = ST_SET;
        else if (!start)                            state_d = ST_PAUSE;
        else if (tick && (sub_second(time_q) == '0)) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (clear)      state_d = ST_SET;
        else if (start) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (clear || btn_min || btn_sec) state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase
  end

  // Time update: edits in SET (or leaving DONE), countdown in RUN, clear zeroes.
  always_comb begin
    time_d = time_q;
    case (state_q)
      ST_SET: begin
        if (clear) begin
          time_d = '0;
        end else begin
          time_d = apply_edits(time_q, btn_min, btn_sec);
`ifdef COOK_TIMER_QUICKSTART_EN
          if (start && (time_q == '0)) time_d = QUICK_TIME;
`endif
        end
      end
      ST_RUN: begin
        if (clear)     time_d = '0;
        else if (tick) time_d = sub_second(time_q);
      end
      ST_PAUSE: begin
        if (clear) time_d = '0;
      end
      ST_DONE: begin
        if (clear)                   time_d = '0;
        else if (btn_min || btn_sec) time_d = apply_edits('0, btn_min, btn_sec);
      end
      default: time_d = '0;
    endcase
  end

  assign min_bcd = {time_q.min_tens, time_q.min_ones};
  assign sec_bcd = {time_q.sec_tens, time_q.sec_ones};

endmodule
